// File: rtl/pe_write_packer_if.sv
// Bundle between the PE array outputs, the flush control and the BRAM write port.
// master drives lane bytes, flush and wr_ready; slave is the packer.
interface pe_write_packer_if #(
  parameter int ADDR_W = 13
);
  logic [15:0]          pe_valid;
  logic [127:0]         pe_data;
  logic [16*ADDR_W-1:0] pe_addr;
  logic [15:0]          pe_ready;
  logic                 flush;
  logic                 flush_busy;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    wr_addr;
  logic [127:0]         wr_data;
  logic [15:0]          wr_be;

  modport master (
    output pe_valid, pe_data, pe_addr, flush, wr_ready,
    input  pe_ready, flush_busy, wr_valid, wr_addr, wr_data, wr_be
  );

  modport slave (
    input  pe_valid, pe_data, pe_addr, flush, wr_ready,
    output pe_ready, flush_busy, wr_valid, wr_addr, wr_data, wr_be
  );
endinterface

// File: rtl/pe_write_packer.sv
// Merges tagged per-lane PE bytes into 128-bit lines with byte enables.
// Optional line counters: define PE_WRITE_PACKER_STATS_EN.
module pe_write_packer #(
  parameter int ADDR_W       = 13,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  pe_write_packer_if.slave bus
`ifdef PE_WRITE_PACKER_STATS_EN
  ,
  output logic [15:0] stat_lines,
  output logic [15:0] stat_partial
`endif
);

  localparam int TW = ADDR_W - 4;
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  logic              acc_vld;
  logic [TW-1:0]     acc_tag;
  logic [127:0]      acc_data;
  logic [15:0]       acc_be;
  logic [CW-1:0]     idle_cnt;
  logic              flush_pend;

  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [127:0]      wr_data_q;
  logic [15:0]       wr_be_q;

  logic [TW-1:0]     lane_tag [16];
  logic [TW-1:0]     first_tag;
  logic [TW-1:0]     target;
  logic [15:0]       match;
  logic [15:0]       acc_mask;
  logic              conflict;
  logic              any_acc;
  logic              out_free;
  logic [127:0]      m_data;
  logic [15:0]       m_be;
  logic              m_vld;
  logic              to_hit;
  logic              close;
  logic [3:0]        off;

  assign out_free       = !wr_valid_q || bus.wr_ready;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_be      = wr_be_q;
  assign bus.flush_busy = flush_pend;
  assign bus.pe_ready   = acc_mask;

  // Lane tags, target tag selection and per-lane accept mask.
  always_comb begin
    first_tag = '0;
    for (int i = 15; i >= 0; i--) begin
      lane_tag[i] = bus.pe_addr[ADDR_W*i+4 +: TW];
      if (bus.pe_valid[i]) first_tag = lane_tag[i];
    end
    target   = acc_vld ? acc_tag : first_tag;
    match    = '0;
    conflict = 1'b0;
    for (int i = 0; i < 16; i++) begin
      match[i] = bus.pe_valid[i] && (lane_tag[i] == target);
      if (bus.pe_valid[i] && (lane_tag[i] != target)) conflict = 1'b1;
    end
    acc_mask = match & {16{out_free && !rst}};
    any_acc  = |acc_mask;
  end

  // Merge accepted bytes; higher lane index wins on same offset.
  always_comb begin
    m_data = acc_data;
    m_be   = acc_be;
    off    = '0;
    for (int i = 0; i < 16; i++) begin
      if (acc_mask[i]) begin
        off = bus.pe_addr[ADDR_W*i +: 4];
        m_data[{off, 3'b000} +: 8] = bus.pe_data[8*i +: 8];
        m_be[off] = 1'b1;
      end
    end
    m_vld  = acc_vld || any_acc;
    to_hit = (IDLE_TIMEOUT > 0) && acc_vld &&
             (idle_cnt >= CW'(IDLE_TIMEOUT));
    close  = out_free && m_vld && (m_be != '0) &&
             ((m_be == 16'hFFFF) || conflict ||
              flush_pend || bus.flush || to_hit);
  end

  // Accumulator: open/merge on accept, empty on close.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_vld  <= 1'b0;
      acc_tag  <= '0;
      acc_data <= '0;
      acc_be   <= '0;
    end else if (close) begin
      acc_vld <= 1'b0;
      acc_be  <= '0;
    end else if (any_acc) begin
      acc_vld  <= 1'b1;
      acc_tag  <= target;
      acc_data <= m_data;
      acc_be   <= m_be;
    end
  end

  // Output line register; holds while the BRAM stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else if (close) begin
      wr_valid_q <= 1'b1;
      wr_addr_q  <= {target, 4'b0000};
      wr_data_q  <= m_data;
      wr_be_q    <= m_be;
    end else if (wr_valid_q && bus.wr_ready) begin
      wr_valid_q <= 1'b0;
    end
  end

  // Idle counter; saturates at the limit until the line can close.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (close || any_acc) begin
      idle_cnt <= '0;
    end else if ((IDLE_TIMEOUT > 0) && acc_vld && !to_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Flush request held until the line closes or nothing is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (close || (!acc_vld && !any_acc)) begin
      flush_pend <= 1'b0;
    end else if (bus.flush) begin
      flush_pend <= 1'b1;
    end
  end

`ifdef PE_WRITE_PACKER_STATS_EN
  // Saturating counts of consumed lines and partial lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lines   <= '0;
      stat_partial <= '0;
    end else if (wr_valid_q && bus.wr_ready) begin
      if (stat_lines != 16'hFFFF) stat_lines <= stat_lines + 1'b1;
      if ((wr_be_q != 16'hFFFF) && (stat_partial != 16'hFFFF))
        stat_partial <= stat_partial + 1'b1;
    end
  end
`endif

endmodule
